// File: rtl/mst_pref_mc.sv
// rtl/mst_pref_mc.sv - multi-channel first-word-fall-through prefetch buffer
//
// Keeps one small FIFO per channel topped up from its stream generator while
// prefetch is enabled, and presents the head word of the selected channel.
// Optional feature macro: MST_PREF_FLUSH_EN (per-channel flush).
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   prefena      prefetch enable
//   prefchn      selected channel for refill and read
//   prefreq      pop head word of prefchn
//   prefnempt    per-channel not-empty
//   prefdout     head word of prefchn {TAG, data}, 0 when empty
//   preflen      occupancy of prefchn
//   prefovf      sticky overflow flag
//   prefflush    per-channel flush (ignored unless MST_PREF_FLUSH_EN)
//   genreq       per-channel generator data request
//   gendat       packed generator data, channel c at [c*DW +: DW]

module mst_pref_mc #(
  parameter int              NCH   = 4,
  parameter int              CHW   = 2,
  parameter int              AW    = 2,
  parameter int              DW    = 32,
  parameter int              TAGW  = 4,
  parameter logic [TAGW-1:0] TAG   = 4'hF,
  parameter int              AFULL = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                prefena,
  input  logic [CHW-1:0]      prefchn,
  input  logic                prefreq,
  output logic [NCH-1:0]      prefnempt,
  output logic [TAGW+DW-1:0]  prefdout,
  output logic [AW:0]         preflen,
  output logic                prefovf,
  input  logic [NCH-1:0]      prefflush,
  output logic [NCH-1:0]      genreq,
  input  logic [NCH*DW-1:0]   gendat
);

  localparam int D  = 2 ** AW;
  localparam int WW = TAGW + DW;

  logic [WW-1:0]  r_mem [NCH][D];
  logic [AW-1:0]  r_wrptr [NCH];
  logic [AW-1:0]  r_rdptr [NCH];
  logic [AW:0]    r_len [NCH];
  logic           r_rqv_p1;
  logic [CHW-1:0] r_rqc_p1;
  logic           r_ovf;

  logic [NCH-1:0] w_flush;
  logic [NCH-1:0] w_wr;
  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_nempt;
  logic           w_pend;
  logic           w_datareq;
  logic           w_wr_full;

`ifdef MST_PREF_FLUSH_EN
  assign w_flush = prefflush;
`else
  logic w_unused_flush;
  assign w_unused_flush = ^prefflush;
  assign w_flush        = '0;
`endif

  // A word already requested for the selected channel counts towards its
  // occupancy, so the threshold can never be overshot by one.
  assign w_pend    = r_rqv_p1 & (r_rqc_p1 == prefchn);
  assign w_datareq = prefena & ~w_flush[prefchn] &
                     (({1'b0, r_len[prefchn]} + (AW+2)'(w_pend)) < (AW+2)'(AFULL));

  // Arriving word on a full channel is dropped and flagged.
  assign w_wr_full = r_rqv_p1 & ~w_flush[r_rqc_p1] & (r_len[r_rqc_p1] == (AW+1)'(D));

  always_comb begin
    w_nempt = '0;
    genreq  = '0;
    w_wr    = '0;
    w_pop   = '0;
    for (int c = 0; c < NCH; c++) begin
      w_nempt[c] = (r_len[c] != '0);
      genreq[c]  = w_datareq & (prefchn == CHW'(c));
      // The write targets the channel that issued the request, not prefchn.
      w_wr[c]    = r_rqv_p1 & (r_rqc_p1 == CHW'(c)) & ~w_flush[c] &
                   (r_len[c] != (AW+1)'(D));
      w_pop[c]   = prefreq & (prefchn == CHW'(c)) & w_nempt[c] & ~w_flush[c];
    end
  end

  assign prefnempt = w_nempt;
  assign preflen   = r_len[prefchn];
  assign prefdout  = w_nempt[prefchn] ? r_mem[prefchn][r_rdptr[prefchn]] : '0;
  assign prefovf   = r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rqv_p1 <= 1'b0;
      r_rqc_p1 <= '0;
      r_ovf    <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_len[c]   <= '0;
        r_wrptr[c] <= '0;
        r_rdptr[c] <= '0;
      end
    end else begin
      r_rqv_p1 <= w_datareq;
      r_rqc_p1 <= prefchn;
      if (w_wr_full) r_ovf <= 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (w_flush[c]) begin
          r_len[c]   <= '0;
          r_wrptr[c] <= '0;
          r_rdptr[c] <= '0;
        end else begin
          if (w_wr[c])  r_wrptr[c] <= r_wrptr[c] + AW'(1);
          if (w_pop[c]) r_rdptr[c] <= r_rdptr[c] + AW'(1);
          if (w_wr[c] & ~w_pop[c])      r_len[c] <= r_len[c] + (AW+1)'(1);
          else if (~w_wr[c] & w_pop[c]) r_len[c] <= r_len[c] - (AW+1)'(1);
        end
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst_n && w_wr[c]) r_mem[c][r_wrptr[c]] <= {TAG, gendat[c*DW +: DW]};
    end
  end

endmodule

// File: tb/tb_mst_pref_mc.sv
// tb/tb_mst_pref_mc.sv - self-checking bench for mst_pref_mc

module tb_mst_pref_mc;

  localparam int NCH   = 4;
  localparam int D     = 4;
  localparam int AFULL = 3;
  localparam logic [3:0] TAG = 4'hF;

  typedef logic [35:0] word_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         prefena;
  logic [1:0]   prefchn;
  logic         prefreq;
  logic [3:0]   prefnempt;
  logic [35:0]  prefdout;
  logic [2:0]   preflen;
  logic         prefovf;
  logic [3:0]   prefflush;
  logic [3:0]   genreq;
  logic [127:0] gendat;

  mst_pref_mc dut (
    .clk(clk), .rst_n(rst_n), .prefena(prefena), .prefchn(prefchn),
    .prefreq(prefreq), .prefnempt(prefnempt), .prefdout(prefdout),
    .preflen(preflen), .prefovf(prefovf), .prefflush(prefflush),
    .genreq(genreq), .gendat(gendat)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one queue per channel plus the single in-flight request.
  word_t       mq [NCH][$];
  logic        m_inf;
  logic [1:0]  m_infch;
  logic        m_ovf;
  int          gn   [NCH];
  logic [31:0] base [NCH];
  logic [31:0] stp  [NCH];
  logic [31:0] gdat [NCH];
  logic        use_rand;
  logic [3:0]  g_obs;
  logic [3:0]  last_nempt;
  logic [35:0] last_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; prefena = 1'b0; prefchn = '0; prefreq = 1'b0;
    prefflush = '0; gendat = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      gn[c] = 0;
    end
    m_inf = 1'b0; m_infch = '0; m_ovf = 1'b0;
    #1;
    chk("rst_nempt", prefnempt, 4'b0);
    chk("rst_dout", prefdout, 36'd0);
    chk("rst_len", preflen, 3'd0);
    chk("rst_genreq", genreq, 4'b0);
    chk("rst_ovf", prefovf, 1'b0);
  endtask

  task automatic step(input logic ena, input logic [1:0] ch, input logic req,
                      input logic [3:0] fl);
    int   sz;
    logic pend, dreq, popok;
    logic [3:0] en;
    @(negedge clk);
    prefena = ena; prefchn = ch; prefreq = req; prefflush = fl;
    for (int c = 0; c < NCH; c++) begin
      gdat[c] = use_rand ? $urandom : base[c] + stp[c] * gn[c];
      gendat[c*32 +: 32] = gdat[c];
    end
    #1;
    sz   = mq[ch].size();
    pend = m_inf && (m_infch == ch);
    dreq = ena && !fl[ch] && (sz + int'(pend) < AFULL);
    for (int c = 0; c < NCH; c++) en[c] = (mq[c].size() != 0);
    chk("genreq", genreq, dreq ? (4'b1 << ch) : 4'b0);
    chk("nempt", prefnempt, en);
    chk("len", preflen, 3'(sz));
    chk("dout", prefdout, (sz != 0) ? mq[ch][0] : 36'd0);
    chk("ovf", prefovf, m_ovf);
    g_obs      = genreq;
    last_nempt = prefnempt;
    last_dout  = prefdout;
    popok = req && (sz != 0) && !fl[ch];
    @(posedge clk);
    if (m_inf && !fl[m_infch]) begin
      if (mq[m_infch].size() == D) m_ovf = 1'b1;
      else begin
        mq[m_infch].push_back({TAG, gdat[m_infch]});
        gn[m_infch]++;
      end
    end
    if (popok) void'(mq[ch].pop_front());
    for (int c = 0; c < NCH; c++) if (fl[c]) mq[c].delete();
    m_inf = dreq; m_infch = ch;
  endtask

  // Look at the selected channel between edges without advancing time past one.
  task automatic peek(input string tag, input logic [1:0] ch,
                      input logic [2:0] exp_len, input logic [35:0] exp_dout);
    #1;
    prefena = 1'b0; prefchn = ch; prefreq = 1'b0; prefflush = '0;
    #1;
    chk({tag, "_len"}, preflen, exp_len);
    chk({tag, "_dout"}, prefdout, exp_dout);
    chk({tag, "_nempt"}, prefnempt[ch], exp_len != 0);
  endtask

  initial begin
    int gcnt, k;
    logic [3:0] fl;
    use_rand = 1'b0;
    for (int c = 0; c < NCH; c++) begin base[c] = 32'h0; stp[c] = 32'h1; end

    // Fill ch0 to the threshold.
    base[0] = 32'h11; stp[0] = 32'h11;
    do_reset();
    gcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, 1'b0, 4'b0);
      gcnt += int'(g_obs[0]);
    end
    chk("fill_genreq_cycles", 64'(gcnt), 64'd3);
    peek("fill", 2'd0, 3'd3, 36'hF_0000_0011);

    // Pop ch0 every cycle across pointer wrap.
    k = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'd0, 1'b1, 4'b0);
      if (last_nempt[0]) begin
        chk("pop_order", last_dout, {4'hF, 32'h11 * (k + 1)});
        k++;
      end
    end
    chk("pop_count_ge10", 64'(k >= 10), 64'd1);
    chk("pop_ovf", prefovf, 1'b0);

    // Alternate channels 0 and 1.
    base[0] = 32'hA0; stp[0] = 32'h1; base[1] = 32'hB0;
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 2'(i % 2), 1'b0, 4'b0);
    peek("alt0", 2'd0, 3'd3, 36'hF_0000_00A0);
    peek("alt1", 2'd1, 3'd3, 36'hF_0000_00B0);

    // Pop and write on ch2 in the same cycle at len 2.
    base[2] = 32'hC0;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 1'b0, 4'b0);
    peek("pw_pre", 2'd2, 3'd2, 36'hF_0000_00C0);
    step(1'b1, 2'd2, 1'b1, 4'b0);
    peek("pw_post", 2'd2, 3'd2, 36'hF_0000_00C1);

    // Pop request on empty ch3 is ignored.
    step(1'b0, 2'd3, 1'b1, 4'b0);
    peek("empty3", 2'd3, 3'd0, 36'd0);
    peek("empty3_ch2", 2'd2, 3'd2, 36'hF_0000_00C1);

`ifdef MST_PREF_FLUSH_EN
    // Flush ch1 while a write is in flight.
    base[1] = 32'hD0;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 1'b0, 4'b0);
    step(1'b0, 2'd1, 1'b0, 4'b0010);
    peek("flush", 2'd1, 3'd0, 36'd0);
    step(1'b0, 2'd1, 1'b0, 4'b0);
    step(1'b0, 2'd1, 1'b0, 4'b0);
    peek("flush_late", 2'd1, 3'd0, 36'd0);
`endif

    // Randomised traffic against the queue model.
    use_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      fl = 4'b0;
`ifdef MST_PREF_FLUSH_EN
      if ($urandom_range(31, 0) == 0) fl = 4'(1 << $urandom_range(3, 0));
`endif
      step($urandom_range(9, 0) < 7, 2'($urandom_range(3, 0)),
           1'($urandom_range(1, 0)), fl);
    end
    chk("rand_ovf", prefovf, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
